// File: rtl/lane_widen_skid_pkg.sv
// Shared definitions for the lane widener slice: skid-buffer state encoding,
// the shift-field width calculation and lane slicing helpers.
package widen_pkg;

   // Occupancy of the two-entry buffer (output register + skid register)
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   // Default geometry: 8-bit capture samples widened for the 16-bit datapath
   localparam int DEF_NUM_LANES = 8;
   localparam int DEF_IN_W      = 8;
   localparam int DEF_OUT_W     = 16;
   localparam int DEF_CNT_W     = 32;

   // Width of the per-beat shift field: enough to encode 0..(OUT_W-IN_W), at least 1 bit
   function automatic int calc_shw(input int in_w, input int out_w);
      int r;
      r = $clog2(out_w - in_w + 1);
      return (r < 1) ? 1 : r;
   endfunction

   // Low bit index of a lane inside a packed multi-lane bus
   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/lane_widen_skid_if.sv
// Valid/ready stream bundle for the lane widener: input beat side with its
// per-beat extension controls, and the widened output beat side.
interface lane_widen_skid_if
   import widen_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int IN_W      = DEF_IN_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int SHW       = calc_shw(DEF_IN_W, DEF_OUT_W)
);

   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_LANES*IN_W-1:0]  in_data;
   logic                       in_signed;
   logic [SHW-1:0]             in_shift;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_LANES*OUT_W-1:0] out_data;

   // Producer of input beats and consumer of output beats
   modport master (
      output in_valid, in_data, in_signed, in_shift, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The widener itself
   modport slave (
      input  in_valid, in_data, in_signed, in_shift, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/lane_widen_skid_lane_extend.sv
// Combinational widening of a single lane: zero/sign extension to OUT_W bits
// followed by a left shift clamped so the sample can never overflow.
module lane_extend #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16,
   parameter int SHW   = 4
) (
   input  logic [IN_W-1:0]  lane,
   input  logic             is_signed,
   input  logic [SHW-1:0]   shift,
   output logic [OUT_W-1:0] res
);

   generate
      if (OUT_W == IN_W) begin : g_pass
         // Equal widths leave no headroom, so the sample passes through unshifted
         assign res = lane;
      end else begin : g_widen
         localparam int MAXSH = OUT_W - IN_W;

         logic [OUT_W-1:0] ext;
         logic [SHW-1:0]   sh_c;

         // Extend, clamp the shift to the available headroom, then shift
         always_comb begin
            ext  = is_signed ? {{MAXSH{lane[IN_W-1]}}, lane} : {{MAXSH{1'b0}}, lane};
            sh_c = (shift > SHW'(MAXSH)) ? SHW'(MAXSH) : shift;
            res  = ext << sh_c;
         end
      end
   endgenerate

endmodule

// File: rtl/lane_widen_skid.sv
// Multi-lane sample widener with a two-entry skid buffer.
// Each accepted beat is widened lane by lane on the way in, then held in the
// output register or, under backpressure, the skid register.
// Optional feature: define WIDEN_CNT_EN to add the beat_count output, a
// wrapping count of delivered output beats.
module lane_widen_skid
   import widen_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int IN_W      = DEF_IN_W,
   parameter int OUT_W     = DEF_OUT_W
`ifdef WIDEN_CNT_EN
   ,
   parameter int CNT_W     = DEF_CNT_W
`endif
) (
   input  logic            clk,
   input  logic            rst,
   lane_widen_skid_if.slave bus
`ifdef WIDEN_CNT_EN
   ,
   output logic [CNT_W-1:0] beat_count
`endif
);

   localparam int SHW = calc_shw(IN_W, OUT_W);

   skid_state_t state;
   skid_state_t next_state;

   logic [NUM_LANES*OUT_W-1:0] res_beat;
   logic [NUM_LANES*OUT_W-1:0] out_reg;
   logic [NUM_LANES*OUT_W-1:0] skid_reg;

   logic in_ready_r;
   logic out_valid_c;
   logic in_fire;
   logic out_fire;
   logic load_out_res;
   logic load_out_skid;
   logic load_skid;

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         lane_extend #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHW   (SHW)
         ) u_ext (
            .lane      (bus.in_data[lane_lo(i, IN_W) +: IN_W]),
            .is_signed (bus.in_signed),
            .shift     (bus.in_shift),
            .res       (res_beat[lane_lo(i, OUT_W) +: OUT_W])
         );
      end
   endgenerate

   assign in_fire  = bus.in_valid & in_ready_r;
   assign out_fire = out_valid_c & bus.out_ready;

   // Buffer occupancy register; reset drops every queued beat
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Occupancy transitions from the input and output handshakes
   always_comb begin
      next_state = state;
      case (state)
         EMPTY: begin
            if (in_fire) next_state = ONE;
         end
         ONE: begin
            if (in_fire && !out_fire)      next_state = TWO;
            else if (!in_fire && out_fire) next_state = EMPTY;
         end
         TWO: begin
            if (out_fire) next_state = ONE;
         end
         default: next_state = EMPTY;
      endcase
   end

   // Decode which data register loads this cycle and whether output is valid
   always_comb begin
      out_valid_c   = (state != EMPTY);
      load_out_res  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         EMPTY: begin
            load_out_res = in_fire;
         end
         ONE: begin
            load_out_res = in_fire & out_fire;
            load_skid    = in_fire & ~out_fire;
         end
         TWO: begin
            load_out_skid = out_fire;
         end
         default: begin
            load_out_res = 1'b0;
         end
      endcase
   end

   // in_ready is registered from the next occupancy so it never follows out_ready combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_r <= 1'b0;
      end else begin
         in_ready_r <= (next_state != TWO);
      end
   end

   // Output and skid data registers; output holds while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg  <= '0;
         skid_reg <= '0;
      end else begin
         if (load_out_res)       out_reg <= res_beat;
         else if (load_out_skid) out_reg <= skid_reg;
         if (load_skid)          skid_reg <= res_beat;
      end
   end

`ifdef WIDEN_CNT_EN
   // Count delivered output beats, wrapping naturally at the counter width
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_count <= '0;
      end else if (out_fire) begin
         beat_count <= beat_count + 1'b1;
      end
   end
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_reg;

endmodule

// File: tb/tb_lane_widen_skid.sv
// Directed self-checking bench for lane_widen_skid (8 lanes, 8 -> 16 bits).
// Covers reset, zero/sign extension with clamped shift, backpressure through
// the skid buffer, sustained streaming and reset while full.
// Define WIDEN_CNT_EN to also check beat_count.
module tb_lane_widen_skid;

   localparam int NL    = 8;
   localparam int IW    = 8;
   localparam int OW    = 16;
   localparam int SH    = 4;
   localparam int CW    = 32;

   logic clk;
   logic rst;
`ifdef WIDEN_CNT_EN
   logic [CW-1:0] beat_count;
`endif

   int check_count;
   int fail_count;

   lane_widen_skid_if #(.NUM_LANES(NL), .IN_W(IW), .OUT_W(OW), .SHW(SH)) bus ();

   lane_widen_skid #(
      .NUM_LANES (NL),
      .IN_W      (IW),
      .OUT_W     (OW)
`ifdef WIDEN_CNT_EN
      ,
      .CNT_W     (CW)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef WIDEN_CNT_EN
      ,
      .beat_count (beat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [NL*IW-1:0] d,
                                input logic s, input logic [SH-1:0] sh);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_signed = s;
      bus.in_shift  = sh;
   endtask

   // Offer one beat into an empty buffer with out_ready high and check the
   // widened result appears next cycle for exactly one cycle
   task automatic singleBeat(input string tag, input logic [NL*IW-1:0] d,
                             input logic s, input logic [SH-1:0] sh,
                             input logic [NL*OW-1:0] exp_data);
      applyStimulus(1'b1, d, s, sh);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput({tag, "_valid"}, 160'(bus.out_valid), 160'(1));
      checkOutput({tag, "_data"}, 160'(bus.out_data), 160'(exp_data));
      step();
      checkOutput({tag, "_gone"}, 160'(bus.out_valid), 160'(0));
   endtask

   logic [NL*OW-1:0] exp_beat;
   logic [NL*IW-1:0] in_beat;

   initial begin
      check_count = 0;
      fail_count  = 0;
      rst = 1'b1;
      bus.out_ready = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0);

      // Reset held for two cycles
      step();
      step();
      checkOutput("rst_out_valid", 160'(bus.out_valid), 160'(0));
      checkOutput("rst_out_data", 160'(bus.out_data), 160'(0));
      checkOutput("rst_in_ready", 160'(bus.in_ready), 160'(0));
`ifdef WIDEN_CNT_EN
      checkOutput("rst_count", 160'(beat_count), 160'(0));
`endif
      rst = 1'b0;
      step();
      checkOutput("post_rst_in_ready", 160'(bus.in_ready), 160'(1));
      checkOutput("post_rst_out_valid", 160'(bus.out_valid), 160'(0));

      // Extension and clamped shift vectors
      bus.out_ready = 1'b1;
      singleBeat("zext_80", {8{8'h80}}, 1'b0, 4'd0, {8{16'h0080}});
      singleBeat("sext_80", {8{8'h80}}, 1'b1, 4'd0, {8{16'hFF80}});
      singleBeat("sext_sh4", {8{8'h80}}, 1'b1, 4'd4, {8{16'hF800}});
      singleBeat("sext_sh12", {8{8'h80}}, 1'b1, 4'd12, {8{16'h8000}});
      singleBeat("sext_7f_sh8", {8{8'h7F}}, 1'b1, 4'd8, {8{16'h7F00}});
      singleBeat("zext_ff_sh15", {8{8'hFF}}, 1'b0, 4'd15, {8{16'hFF00}});
      singleBeat("mixed_lanes", 64'h00000000_01FF807F, 1'b1, 4'd1,
                 128'h0000_0000_0000_0000_0002_FFFE_FF00_00FE);

      // Backpressure: A and B fill the buffer, C waits
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, {8{8'h11}}, 1'b0, 4'd0);
      step();
      checkOutput("bp_a_out", 160'(bus.out_data), 160'({8{16'h0011}}));
      checkOutput("bp_a_ready", 160'(bus.in_ready), 160'(1));
      applyStimulus(1'b1, {8{8'h22}}, 1'b0, 4'd0);
      step();
      checkOutput("bp_full_ready", 160'(bus.in_ready), 160'(0));
      applyStimulus(1'b1, {8{8'h33}}, 1'b0, 4'd0);
      step();
      checkOutput("bp_hold1", 160'({bus.out_valid, bus.in_ready, bus.out_data}),
                  160'({1'b1, 1'b0, {8{16'h0011}}}));
      step();
      checkOutput("bp_hold2", 160'({bus.out_valid, bus.in_ready, bus.out_data}),
                  160'({1'b1, 1'b0, {8{16'h0011}}}));
      bus.out_ready = 1'b1;
      step();
      checkOutput("bp_b_out", 160'({bus.out_valid, bus.in_ready, bus.out_data}),
                  160'({1'b1, 1'b1, {8{16'h0022}}}));
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("bp_c_out", 160'({bus.out_valid, bus.out_data}),
                  160'({1'b1, {8{16'h0033}}}));
      step();
      checkOutput("bp_drained", 160'(bus.out_valid), 160'(0));

      // Fresh reset so the streaming run starts the counter at zero
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      // Streaming 100 beats with an incrementing per-lane pattern
      for (int k = 0; k < 100; k++) begin
         for (int l = 0; l < NL; l++) begin
            in_beat[l*IW +: IW]  = 8'(k + l);
            exp_beat[l*OW +: OW] = 16'(8'(k + l));
         end
         applyStimulus(1'b1, in_beat, 1'b0, 4'd0);
         step();
         checkOutput($sformatf("stream_%0d", k),
                     160'({bus.out_valid, bus.in_ready, bus.out_data}),
                     160'({1'b1, 1'b1, exp_beat}));
      end
      applyStimulus(1'b0, '0, 1'b0, '0);
      step();
      checkOutput("stream_end", 160'(bus.out_valid), 160'(0));
`ifdef WIDEN_CNT_EN
      checkOutput("stream_count", 160'(beat_count), 160'(100));
`endif

      // Fill to TWO, then reset mid-operation
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, {8{8'h44}}, 1'b0, 4'd0);
      step();
      applyStimulus(1'b1, {8{8'h55}}, 1'b0, 4'd0);
      step();
      checkOutput("mid_full", 160'({bus.out_valid, bus.in_ready}), 160'({1'b1, 1'b0}));
      applyStimulus(1'b0, {8{8'h66}}, 1'b1, 4'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("mid_rst_valid", 160'(bus.out_valid), 160'(0));
      checkOutput("mid_rst_data", 160'(bus.out_data), 160'(0));
`ifdef WIDEN_CNT_EN
      checkOutput("mid_rst_count", 160'(beat_count), 160'(0));
`endif
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checkOutput($sformatf("mid_no_emerge_%0d", k),
                     160'({bus.out_valid, bus.in_ready}), 160'({1'b0, 1'b1}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
